alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 188 ++++++++++++++++++
 tb/tb_alu_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
//
// Shares one external combinational ALU between two requesters. A request is
// granted round-robin in IDLE and its operands/controls are registered onto
// the alu_* outputs. One cycle later (ISSUE) the ALU result is captured. The
// block then holds the response (RESP) until the consumer accepts it.
//
// Ports
//   clk         rising-edge clock
//   rst         asynchronous, active-low reset
//   req_valid   per-requester request valid (bit i = requester i)
//   req_ready   per-requester accept, one-hot on the grant, IDLE only
//   req_rs1/2   packed operands, requester i at [i*WIDTH +: WIDTH]
//   req_ctrl    packed controls, requester i at [i*34 +: 34] as
//               {funct7, funct3, opcode, imm, shamt}
//   alu_*       registered operands/controls presented to the ALU
//   alu_rd      combinational ALU result
//   rsp_valid   response valid; rsp_ready is the consumer accept
//   rsp_data    captured result (0 when rsp_err)
//   rsp_id      requester the response belongs to
//   rsp_err     opcode was neither OP (0110011) nor OP-IMM (0010011)
//   busy        high whenever the FSM is not in IDLE
// ---------------------------------------------------------------------------
module alu_arbiter #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [2*WIDTH-1:0] req_rs1,
    input  logic [2*WIDTH-1:0] req_rs2,
    input  logic [67:0]        req_ctrl,
    output logic [WIDTH-1:0]   alu_rs1,
    output logic [WIDTH-1:0]   alu_rs2,
    output logic [2:0]         alu_funct3,
    output logic [6:0]         alu_funct7,
    output logic [6:0]         alu_opcode,
    output logic [11:0]        alu_imm,
    output logic [4:0]         alu_shamt,
    input  logic [WIDTH-1:0]   alu_rd,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [WIDTH-1:0]   rsp_data,
    output logic               rsp_id,
    output logic               rsp_err,
    output logic               busy
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               ptr_q, ptr_d;
    logic [WIDTH-1:0]   alu_rs1_q, alu_rs1_d;
    logic [WIDTH-1:0]   alu_rs2_q, alu_rs2_d;
    logic [33:0]        alu_ctrl_q, alu_ctrl_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
    logic               rsp_id_q, rsp_id_d;
    logic               rsp_err_q, rsp_err_d;

    logic               grant_vld;
    logic               grant_idx;
    logic [WIDTH-1:0]   sel_rs1;
    logic [WIDTH-1:0]   sel_rs2;
    logic [33:0]        sel_ctrl;
    logic               op_is_err;

    // Round-robin pick: the pointer's requester wins if valid, else the other.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = ptr_q;
        if (req_valid[ptr_q]) begin
            grant_vld = 1'b1;
            grant_idx = ptr_q;
        end else if (req_valid[~ptr_q]) begin
            grant_vld = 1'b1;
            grant_idx = ~ptr_q;
        end
    end

    // Operand/control mux for the granted requester.
    always_comb begin
        sel_rs1  = grant_idx ? req_rs1[2*WIDTH-1:WIDTH] : req_rs1[WIDTH-1:0];
        sel_rs2  = grant_idx ? req_rs2[2*WIDTH-1:WIDTH] : req_rs2[WIDTH-1:0];
        sel_ctrl = grant_idx ? req_ctrl[67:34] : req_ctrl[33:0];
    end

    // Ready is gated by reset so that it drops immediately when rst goes low,
    // even though req_valid may still be driven.
    always_comb begin
        req_ready = 2'b00;
        if (rst && (state_q == IDLE) && grant_vld) begin
            req_ready = 2'b01 << grant_idx;
        end
    end

    assign op_is_err = (alu_ctrl_q[23:17] != OPC_OP) &&
                       (alu_ctrl_q[23:17] != OPC_OP_IMM);

    // Next-state and register-update logic for the shared-ALU transaction.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        alu_rs1_d   = alu_rs1_q;
        alu_rs2_d   = alu_rs2_q;
        alu_ctrl_d  = alu_ctrl_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (grant_vld) begin
                    alu_rs1_d  = sel_rs1;
                    alu_rs2_d  = sel_rs2;
                    alu_ctrl_d = sel_ctrl;
                    rsp_id_d   = grant_idx;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                rsp_err_d   = op_is_err;
                rsp_data_d  = op_is_err ? '0 : alu_rd;
                rsp_valid_d = 1'b1;
                state_d     = RESP;
            end
            RESP: begin
                // The pointer moves past whoever was just served.
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    ptr_d       = ~rsp_id_q;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            ptr_q       <= 1'b0;
            alu_rs1_q   <= '0;
            alu_rs2_q   <= '0;
            alu_ctrl_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            alu_rs1_q   <= alu_rs1_d;
            alu_rs2_q   <= alu_rs2_d;
            alu_ctrl_q  <= alu_ctrl_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign alu_rs1    = alu_rs1_q;
    assign alu_rs2    = alu_rs2_q;
    assign alu_funct7 = alu_ctrl_q[33:27];
    assign alu_funct3 = alu_ctrl_q[26:24];
    assign alu_opcode = alu_ctrl_q[23:17];
    assign alu_imm    = alu_ctrl_q[16:5];
    assign alu_shamt  = alu_ctrl_q[4:0];
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign rsp_id     = rsp_id_q;
    assign rsp_err    = rsp_err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
//
// Requesters hold queues of pending operations. A driver presents the heads
// each cycle, predicts the round-robin grant from a transaction-level model
// and pushes the expected response into a scoreboard. A separate monitor pops
// and compares whenever the DUT presents a response. The ALU itself is a
// behavioural RV32I OP/OP-IMM model driven from the DUT's alu_* outputs.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;

    localparam int W = 32;
    localparam logic [6:0] OP_R = 7'b0110011;
    localparam logic [6:0] OP_I = 7'b0010011;

    typedef struct {
        logic [W-1:0] rs1;
        logic [W-1:0] rs2;
        logic [33:0]  ctrl;
    } op_t;

    typedef struct {
        logic [W-1:0] data;
        logic         id;
        logic         err;
        int           acc;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic [1:0]     req_valid;
    logic [1:0]     req_ready;
    logic [2*W-1:0] req_rs1;
    logic [2*W-1:0] req_rs2;
    logic [67:0]    req_ctrl;
    logic [W-1:0]   alu_rs1;
    logic [W-1:0]   alu_rs2;
    logic [2:0]     alu_funct3;
    logic [6:0]     alu_funct7;
    logic [6:0]     alu_opcode;
    logic [11:0]    alu_imm;
    logic [4:0]     alu_shamt;
    logic [W-1:0]   alu_rd;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [W-1:0]   rsp_data;
    logic           rsp_id;
    logic           rsp_err;
    logic           busy;

    op_t  reqq[2][$];
    exp_t sb[$];
    op_t  last_acc;
    logic model_idle;
    logic model_p;
    int   cyc;
    int   busy_cnt;
    int   n_checks;
    int   n_fail;
    bit   mon_prev;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_ctrl   (req_ctrl),
        .alu_rs1    (alu_rs1),
        .alu_rs2    (alu_rs2),
        .alu_funct3 (alu_funct3),
        .alu_funct7 (alu_funct7),
        .alu_opcode (alu_opcode),
        .alu_imm    (alu_imm),
        .alu_shamt  (alu_shamt),
        .alu_rd     (alu_rd),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_id     (rsp_id),
        .rsp_err    (rsp_err),
        .busy       (busy)
    );

    // Behavioural ALU; unknown opcodes give nonzero garbage so that the
    // error path must force the response data to zero.
    function automatic logic [W-1:0] alu_model(input logic [6:0] f7, input logic [2:0] f3,
                                               input logic [6:0] opc, input logic [11:0] imm,
                                               input logic [4:0] sh, input logic [W-1:0] a,
                                               input logic [W-1:0] b);
        logic [W-1:0] ix;
        logic [W-1:0] r;
        ix = {{(W-12){imm[11]}}, imm};
        r  = a ^ b ^ 32'hA5A5_0001;
        if (opc == OP_R) begin
            case (f3)
                3'd0: r = f7[5] ? a - b : a + b;
                3'd1: r = a << b[4:0];
                3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                3'd3: r = (a < b) ? 32'd1 : 32'd0;
                3'd4: r = a ^ b;
                3'd5: r = f7[5] ? W'($signed(a) >>> b[4:0]) : a >> b[4:0];
                3'd6: r = a | b;
                default: r = a & b;
            endcase
        end else if (opc == OP_I) begin
            case (f3)
                3'd0: r = a + ix;
                3'd1: r = a << sh;
                3'd2: r = ($signed(a) < $signed(ix)) ? 32'd1 : 32'd0;
                3'd3: r = (a < ix) ? 32'd1 : 32'd0;
                3'd4: r = a ^ ix;
                3'd5: r = f7[5] ? W'($signed(a) >>> sh) : a >> sh;
                3'd6: r = a | ix;
                default: r = a & ix;
            endcase
        end
        return r;
    endfunction

    assign alu_rd = alu_model(alu_funct7, alu_funct3, alu_opcode, alu_imm, alu_shamt,
                              alu_rs1, alu_rs2);

    function automatic op_t make_op(input logic [6:0] f7, input logic [2:0] f3,
                                    input logic [6:0] opc, input logic [11:0] imm,
                                    input logic [4:0] sh, input logic [W-1:0] a,
                                    input logic [W-1:0] b);
        op_t o;
        o.rs1  = a;
        o.rs2  = b;
        o.ctrl = {f7, f3, opc, imm, sh};
        return o;
    endfunction

    function automatic op_t rand_op();
        int         r;
        logic [6:0] opc;
        r   = $urandom_range(0, 9);
        opc = (r < 4) ? OP_R : (r < 8) ? OP_I : (r == 8) ? 7'b1100011 : 7'b0000011;
        return make_op(($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'b0000000,
                       3'($urandom_range(0, 7)), opc, 12'($urandom), 5'($urandom),
                       $urandom, $urandom);
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One negedge-aligned cycle: drive inputs, predict the grant, check.
    task automatic drive_cycle(input bit rr_rand, input logic rr_val, input bit do_rst,
                               input bit rand_push);
        logic [1:0] v;
        logic [1:0] exp_ready;
        int         g;
        op_t        o;
        exp_t       e;
        @(negedge clk);
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (rand_push && reqq[i].size() < 2 && $urandom_range(0, 3) == 0)
                reqq[i].push_back(rand_op());
            v[i] = (reqq[i].size() > 0) &&
                   (model_idle || !rand_push || $urandom_range(0, 1) == 1);
            o = (reqq[i].size() > 0) ? reqq[i][0] : rand_op();
            req_rs1[i*W +: W]   = o.rs1;
            req_rs2[i*W +: W]   = o.rs2;
            req_ctrl[i*34 +: 34] = o.ctrl;
        end
        req_valid = v;
        rsp_ready = rr_rand ? 1'($urandom_range(0, 1)) : rr_val;
        if (do_rst) begin
            rst = 1'b0;
            #1;
            checkOutput("rst_ctl", 64'({rsp_valid, rsp_id, rsp_err, busy, req_ready}), 64'd0);
            checkOutput("rst_data", 64'(rsp_data), 64'd0);
            checkOutput("rst_alu_ops", 64'({alu_rs1, alu_rs2}), 64'd0);
            checkOutput("rst_alu_ctrl",
                        64'({alu_funct7, alu_funct3, alu_opcode, alu_imm, alu_shamt}), 64'd0);
            sb.delete();
            model_idle = 1'b1;
            model_p    = 1'b0;
            last_acc   = make_op('0, '0, '0, '0, '0, '0, '0);
            busy_cnt   = 0;
            return;
        end
        rst = 1'b1;
        #1;
        checkOutput("alu_ops_hold", 64'({alu_rs1, alu_rs2}), 64'({last_acc.rs1, last_acc.rs2}));
        checkOutput("alu_ctrl_hold",
                    64'({alu_funct7, alu_funct3, alu_opcode, alu_imm, alu_shamt}),
                    64'(last_acc.ctrl));
        checkOutput("busy", 64'(busy), 64'(!model_idle));
        exp_ready = 2'b00;
        g = -1;
        if (model_idle) begin
            if (v[model_p]) g = int'(model_p);
            else if (v[!model_p]) g = int'(!model_p);
        end
        if (g >= 0) exp_ready[g] = 1'b1;
        checkOutput("req_ready", 64'(req_ready), 64'(exp_ready));
        if (g >= 0) begin
            o     = reqq[g].pop_front();
            e.id  = 1'(g);
            e.err = (o.ctrl[23:17] != OP_R) && (o.ctrl[23:17] != OP_I);
            e.data = e.err ? '0 : alu_model(o.ctrl[33:27], o.ctrl[26:24], o.ctrl[23:17],
                                            o.ctrl[16:5], o.ctrl[4:0], o.rs1, o.rs2);
            e.acc = cyc;
            sb.push_back(e);
            last_acc   = o;
            model_idle = 1'b0;
            busy_cnt   = 0;
        end else if (!model_idle) begin
            busy_cnt++;
            if (busy_cnt > 40) begin
                n_checks++;
                n_fail++;
                $display("[TB] FAIL rsp_timeout: no response after %0d cycles", busy_cnt);
                sb.delete();
                model_idle = 1'b1;
                busy_cnt   = 0;
            end
        end
    endtask

    task automatic applyStimulus(input int n, input bit rr_rand, input logic rr_val,
                                 input bit rand_push);
        for (int k = 0; k < n; k++) drive_cycle(rr_rand, rr_val, 1'b0, rand_push);
    endtask

    // Monitor: compares the presented response against the scoreboard head
    // every cycle it is valid, which also covers stability while stalled.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                mon_prev = 1'b0;
            end else if (rsp_valid) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("[TB] FAIL spurious_rsp: got rsp_valid=1 expected no response");
                end else begin
                    e = sb[0];
                    checkOutput("rsp_data", 64'(rsp_data), 64'(e.data));
                    checkOutput("rsp_id", 64'(rsp_id), 64'(e.id));
                    checkOutput("rsp_err", 64'(rsp_err), 64'(e.err));
                    if (!mon_prev) checkOutput("rsp_latency", 64'(cyc - e.acc), 64'd2);
                    if (rsp_ready) begin
                        void'(sb.pop_front());
                        model_idle = 1'b1;
                        model_p    = !e.id;
                    end
                end
                mon_prev = rsp_valid && !rsp_ready;
            end else begin
                mon_prev = 1'b0;
            end
        end
    end

    initial begin
        n_checks   = 0;
        n_fail     = 0;
        cyc        = 0;
        busy_cnt   = 0;
        mon_prev   = 1'b0;
        model_idle = 1'b1;
        model_p    = 1'b0;
        last_acc   = make_op('0, '0, '0, '0, '0, '0, '0);
        rst        = 1'b0;
        req_valid  = 2'b00;
        req_rs1    = '0;
        req_rs2    = '0;
        req_ctrl   = '0;
        rsp_ready  = 1'b0;

        drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);
        drive_cycle(1'b0, 1'b0, 1'b1, 1'b0);

        $display("[TB] req0 ADD 5+7");
        reqq[0].push_back(make_op(7'd0, 3'd0, OP_R, 12'd0, 5'd0, 32'd5, 32'd7));
        applyStimulus(6, 1'b0, 1'b1, 1'b0);

        $display("[TB] both requesters continuously valid");
        for (int k = 0; k < 3; k++) begin
            reqq[0].push_back(rand_op());
            reqq[1].push_back(rand_op());
        end
        applyStimulus(22, 1'b0, 1'b1, 1'b0);

        $display("[TB] consumer stall in RESP");
        reqq[0].push_back(rand_op());
        reqq[1].push_back(rand_op());
        applyStimulus(8, 1'b0, 1'b0, 1'b0);
        applyStimulus(10, 1'b0, 1'b1, 1'b0);

        $display("[TB] req1 illegal opcode");
        reqq[1].push_back(make_op(7'd0, 3'd0, 7'b1100011, 12'h010, 5'd0, 32'd3, 32'd4));
        applyStimulus(6, 1'b0, 1'b1, 1'b0);

        $display("[TB] req1 back-to-back ADDI/XOR/OR");
        reqq[1].push_back(make_op(7'd0, 3'd0, OP_I, 12'd3, 5'd0, 32'd10, 32'd99));
        reqq[1].push_back(make_op(7'd0, 3'd4, OP_R, 12'd0, 5'd0, 32'h0000_F0F0, 32'h0000_0FF0));
        reqq[1].push_back(make_op(7'd0, 3'd6, OP_R, 12'd0, 5'd0, 32'h1200_0034, 32'h0056_7800));
        applyStimulus(12, 1'b0, 1'b1, 1'b0);

        $display("[TB] reset during ISSUE");
        reqq[0].push_back(rand_op());
        applyStimulus(6, 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) begin
            reqq[0].push_back(rand_op());
            reqq[1].push_back(rand_op());
        end
        for (int k = 0; k < 10 && model_idle; k++) drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        drive_cycle(1'b0, 1'b1, 1'b1, 1'b0);
        applyStimulus(14, 1'b0, 1'b1, 1'b0);

        $display("[TB] randomized traffic");
        applyStimulus(400, 1'b1, 1'b0, 1'b1);

        for (int k = 0; k < 80 && (reqq[0].size() + reqq[1].size() > 0 || !model_idle); k++)
            drive_cycle(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("drained", 64'(sb.size() + reqq[0].size() + reqq[1].size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
